// File: rtl/rfphoenix_mc_alu_sched_pkg.sv
// Shared types for the multicycle ALU issue/writeback scheduler.
//   mc_cls_t  : latency class of an operation (drives the result mux select).
//   mc_slot_t : one reservation slot. Fields are sized to the largest supported
//               widths. Modules zero-extend their narrower parameters into
//               these fields, and synthesis removes the constant upper bits.
//   popcount  : number of set bits in a 64-bit vector.
package rfphoenix_mc_alu_sched_pkg;

  localparam int MC_TID_W_MAX = 8;
  localparam int MC_RT_W_MAX  = 8;
  localparam int MC_LANES_MAX = 32;
  localparam int MC_DEPTH_MAX = 64;

  typedef enum logic [1:0] {
    MUL = 2'd0,
    FMA = 2'd1,
    CVT = 2'd2,
    EST = 2'd3
  } mc_cls_t;

  typedef struct packed {
    logic                    v;
    logic [MC_TID_W_MAX-1:0] tid;
    logic [MC_RT_W_MAX-1:0]  rt;
    logic [MC_LANES_MAX-1:0] mask;
    mc_cls_t                 cls;
  } mc_slot_t;

  function automatic logic [6:0] popcount(input logic [MC_DEPTH_MAX-1:0] x);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < MC_DEPTH_MAX; i++) begin
      n = n + {6'd0, x[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rfphoenix_wb_resv.sv
// Writeback reservation shift register.
// slot[i] completes i cycles from now. Every clock the array shifts down by
// one and the top slot is refilled with an empty entry. An accepted issue
// overwrites the slot at ins_idx. A flush then clears v on every slot whose
// tid matches; the flush therefore also catches an op inserted at the same edge.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   ins_v/idx/slot  : insert request, target index, slot contents
//   flush_v/tid     : clear v of all slots carrying flush_tid
//   slot0           : current head slot (completing this cycle)
//   v_vec           : current valid bit of each slot
//   count           : registered popcount of the valid bits
module rfphoenix_wb_resv
  import rfphoenix_mc_alu_sched_pkg::*;
#(
  parameter int MAXLAT = 16,
  parameter int IDX_W  = $clog2(MAXLAT),
  parameter int CNT_W  = $clog2(MAXLAT + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ins_v,
  input  logic [IDX_W-1:0]        ins_idx,
  input  mc_slot_t                ins_slot,
  input  logic                    flush_v,
  input  logic [MC_TID_W_MAX-1:0] flush_tid,
  output mc_slot_t                slot0,
  output logic [MAXLAT-1:0]       v_vec,
  output logic [CNT_W-1:0]        count
);

  mc_slot_t          slot_q [MAXLAT];
  mc_slot_t          slot_d [MAXLAT];
  logic [MAXLAT-1:0] v_next;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;

  always_comb begin
    for (int i = 0; i < MAXLAT - 1; i++) begin
      slot_d[i] = slot_q[i+1];
    end
    slot_d[MAXLAT-1] = '0;
    for (int i = 0; i < MAXLAT; i++) begin
      if (ins_v && (ins_idx == IDX_W'(i))) begin
        slot_d[i] = ins_slot;
      end
      if (flush_v && (slot_d[i].tid == flush_tid)) begin
        slot_d[i].v = 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAXLAT; gi++) begin : g_vbits
      assign v_vec[gi]  = slot_q[gi].v;
      assign v_next[gi] = slot_d[gi].v;
    end
  endgenerate

  // The count is taken from the next state so it lines up with the slots after the edge.
  always_comb begin
    count_d = CNT_W'(popcount(MC_DEPTH_MAX'(v_next)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAXLAT; i++) begin
        slot_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < MAXLAT; i++) begin
        slot_q[i] <= slot_d[i];
      end
      count_q <= count_d;
    end
  end

  assign slot0 = slot_q[0];
  assign count = count_q;

endmodule

// File: rtl/rfphoenix_mc_alu_sched.sv
// Issue and writeback scheduler for the multicycle ALU lanes.
// One op per cycle is accepted with a latency class. The op is reserved in the
// single writeback slot L cycles ahead, and done pulses when it completes.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   issue_v/rdy              : issue handshake (rdy is combinational in issue_cls)
//   issue_cls/tid/rt/mask    : operation tag
//   flush_v/flush_tid        : per-thread flush of in-flight ops
//   done, rido, rt_o, mask_o : completing op (fields are 0 when not done)
//   sel_o                    : class of completing op, drives the result mux
//   busy, inflight           : any op in flight / number of valid slots
module rfphoenix_mc_alu_sched
  import rfphoenix_mc_alu_sched_pkg::*;
#(
  parameter int TID_W   = 4,
  parameter int LANES   = 4,
  parameter int RT_W    = 6,
  parameter int MAXLAT  = 16,
  parameter int LAT_MUL = 8,
  parameter int LAT_FMA = 8,
  parameter int LAT_CVT = 7,
  parameter int LAT_EST = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_v,
  output logic                         issue_rdy,
  input  logic [1:0]                   issue_cls,
  input  logic [TID_W-1:0]             issue_tid,
  input  logic [RT_W-1:0]              issue_rt,
  input  logic [LANES-1:0]             issue_mask,
  input  logic                         flush_v,
  input  logic [TID_W-1:0]             flush_tid,
  output logic                         done,
  output logic [TID_W-1:0]             rido,
  output logic [RT_W-1:0]              rt_o,
  output logic [LANES-1:0]             mask_o,
  output logic [1:0]                   sel_o,
  output logic                         busy,
  output logic [$clog2(MAXLAT+1)-1:0]  inflight
);

  localparam int IDX_W = $clog2(MAXLAT);
  localparam int CNT_W = $clog2(MAXLAT + 1);

  // Reject configurations the slot array cannot represent.
  generate
    if (LAT_MUL < 1 || LAT_MUL > MAXLAT - 1 || LAT_FMA < 1 || LAT_FMA > MAXLAT - 1 ||
        LAT_CVT < 1 || LAT_CVT > MAXLAT - 1 || LAT_EST < 1 || LAT_EST > MAXLAT - 1) begin : g_bad_lat
      $error("rfphoenix_mc_alu_sched: class latency outside 1..MAXLAT-1");
    end
    if (MAXLAT < 2 || MAXLAT > MC_DEPTH_MAX || TID_W > MC_TID_W_MAX ||
        RT_W > MC_RT_W_MAX || LANES > MC_LANES_MAX) begin : g_bad_size
      $error("rfphoenix_mc_alu_sched: parameter exceeds supported range");
    end
  endgenerate

  logic [IDX_W-1:0]  lat;
  logic [IDX_W-1:0]  ins_idx;
  logic              accept;
  mc_slot_t          ins_slot;
  mc_slot_t          slot0;
  logic [MAXLAT-1:0] v_vec;
  logic              slot0_unused;

  always_comb begin
    case (issue_cls)
      2'd0:    lat = IDX_W'(LAT_MUL);
      2'd1:    lat = IDX_W'(LAT_FMA);
      2'd2:    lat = IDX_W'(LAT_CVT);
      default: lat = IDX_W'(LAT_EST);
    endcase
  end

  // slot[L] is what shifts into slot[L-1] this edge. If it is occupied, the
  // new op would share a writeback cycle with it.
  assign issue_rdy = rst & ~v_vec[lat];
  assign accept    = issue_v & issue_rdy;
  assign ins_idx   = lat - IDX_W'(1);

  always_comb begin
    ins_slot      = '0;
    ins_slot.v    = 1'b1;
    ins_slot.tid  = MC_TID_W_MAX'(issue_tid);
    ins_slot.rt   = MC_RT_W_MAX'(issue_rt);
    ins_slot.mask = MC_LANES_MAX'(issue_mask);
    ins_slot.cls  = mc_cls_t'(issue_cls);
  end

  rfphoenix_wb_resv #(
    .MAXLAT (MAXLAT),
    .IDX_W  (IDX_W),
    .CNT_W  (CNT_W)
  ) u_resv (
    .clk       (clk),
    .rst       (rst),
    .ins_v     (accept),
    .ins_idx   (ins_idx),
    .ins_slot  (ins_slot),
    .flush_v   (flush_v),
    .flush_tid (MC_TID_W_MAX'(flush_tid)),
    .slot0     (slot0),
    .v_vec     (v_vec),
    .count     (inflight)
  );

  // A flushed slot keeps its tag with v cleared, so the tag fields are gated.
  assign done   = slot0.v;
  assign rido   = slot0.v ? slot0.tid[TID_W-1:0]   : '0;
  assign rt_o   = slot0.v ? slot0.rt[RT_W-1:0]     : '0;
  assign mask_o = slot0.v ? slot0.mask[LANES-1:0]  : '0;
  assign sel_o  = slot0.v ? slot0.cls              : 2'd0;
  assign busy   = |v_vec;

  // The upper tag bits beyond the configured widths are always zero.
  assign slot0_unused = ^slot0;

endmodule

// File: tb/tb_rfphoenix_mc_alu_sched.sv
module tb_rfphoenix_mc_alu_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_v;
  logic       issue_rdy;
  logic [1:0] issue_cls;
  logic [3:0] issue_tid;
  logic [5:0] issue_rt;
  logic [3:0] issue_mask;
  logic       flush_v;
  logic [3:0] flush_tid;
  logic       done;
  logic [3:0] rido;
  logic [5:0] rt_o;
  logic [3:0] mask_o;
  logic [1:0] sel_o;
  logic       busy;
  logic [4:0] inflight;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rfphoenix_mc_alu_sched dut (
    .clk        (clk),
    .rst        (rst),
    .issue_v    (issue_v),
    .issue_rdy  (issue_rdy),
    .issue_cls  (issue_cls),
    .issue_tid  (issue_tid),
    .issue_rt   (issue_rt),
    .issue_mask (issue_mask),
    .flush_v    (flush_v),
    .flush_tid  (flush_tid),
    .done       (done),
    .rido       (rido),
    .rt_o       (rt_o),
    .mask_o     (mask_o),
    .sel_o      (sel_o),
    .busy       (busy),
    .inflight   (inflight)
  );

  typedef struct {
    logic       iv;
    logic [1:0] cls;
    logic [3:0] tid;
    logic [5:0] rt;
    logic [3:0] mask;
    logic       fv;
    logic [3:0] ftid;
    logic       rdy;
    logic       done;
    logic [3:0] rido;
    logic [5:0] rto;
    logic [3:0] masko;
    logic [1:0] sel;
    int         infl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iv, input logic [1:0] cls, input logic [3:0] tid,
                     input logic [5:0] rt, input logic [3:0] mask, input logic fv,
                     input logic [3:0] ftid, input logic rdy, input logic dn,
                     input logic [3:0] rido_e, input logic [5:0] rt_e,
                     input logic [3:0] mask_e, input logic [1:0] sel_e, input int infl);
    vec_t v;
    v.iv = iv; v.cls = cls; v.tid = tid; v.rt = rt; v.mask = mask;
    v.fv = fv; v.ftid = ftid; v.rdy = rdy; v.done = dn; v.rido = rido_e;
    v.rto = rt_e; v.masko = mask_e; v.sel = sel_e; v.infl = infl;
    vecs.push_back(v);
  endtask

  task automatic idle(input int n, input int infl);
    for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, infl);
  endtask

  task automatic issue(input logic [1:0] cls, input logic [3:0] tid, input logic [5:0] rt,
                       input logic [3:0] mask, input logic rdy, input int infl);
    add(1, cls, tid, rt, mask, 0, 0, rdy, 0, 0, 0, 0, 0, infl);
  endtask

  task automatic fin(input logic [3:0] tid, input logic [5:0] rt, input logic [3:0] mask,
                     input logic [1:0] sel, input int infl);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, tid, rt, mask, sel, infl);
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    issue_v = 0; issue_cls = 0; issue_tid = 0; issue_rt = 0; issue_mask = 0;
    flush_v = 0; flush_tid = 0;
  endtask

  task automatic check_zero_out(input string tag);
    check({tag, " done"}, done, 0);
    check({tag, " rido"}, rido, 0);
    check({tag, " rt_o"}, rt_o, 0);
    check({tag, " mask_o"}, mask_o, 0);
    check({tag, " sel_o"}, sel_o, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " inflight"}, inflight, 0);
  endtask

  initial begin
    // Single MUL op: done in cycle 8, inflight 1 in cycles 1..8.
    issue(0, 3, 5, 4'hF, 1, 0);
    idle(7, 1);
    fin(3, 5, 4'hF, 0, 1);
    idle(1, 0);
    // Collision: FMA at cycle 0, EST offered from cycle 3, stalled one cycle.
    issue(1, 1, 2, 4'h3, 1, 0);
    idle(2, 1);
    issue(3, 4, 7, 4'h8, 0, 1);
    issue(3, 4, 7, 4'h8, 1, 1);
    idle(3, 2);
    fin(1, 2, 4'h3, 1, 2);
    fin(4, 7, 4'h8, 3, 1);
    idle(1, 0);
    // Back-to-back MULs, tids 0..3.
    for (int i = 0; i < 4; i++) issue(0, 4'(i), 6'(10 + i), 4'(1 << i), 1, i);
    idle(4, 4);
    for (int i = 0; i < 4; i++) fin(4'(i), 6'(10 + i), 4'(1 << i), 0, 4 - i);
    idle(1, 0);
    // Flush tid 2 in cycle 3; a non-matching flush in cycle 2 changes nothing.
    issue(2, 2, 1, 4'h1, 1, 0);
    issue(2, 1, 2, 4'h2, 1, 1);
    add(0, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 2);
    idle(4, 1);
    fin(1, 2, 4'h2, 2, 1);
    idle(1, 0);
    // Same-cycle issue and flush of tid 6: consumed, nothing completes.
    add(1, 1, 6, 9, 4'h5, 1, 6, 1, 0, 0, 0, 0, 0, 0);
    idle(10, 0);

    drive_idle();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_out("reset");
    check("reset issue_rdy", issue_rdy, 0);
    rst = 1;
    step();

    for (int k = 0; k < vecs.size(); k++) begin
      issue_v = vecs[k].iv; issue_cls = vecs[k].cls; issue_tid = vecs[k].tid;
      issue_rt = vecs[k].rt; issue_mask = vecs[k].mask;
      flush_v = vecs[k].fv; flush_tid = vecs[k].ftid;
      #1;
      check($sformatf("v%0d issue_rdy", k), issue_rdy, vecs[k].rdy);
      check($sformatf("v%0d done", k), done, vecs[k].done);
      check($sformatf("v%0d rido", k), rido, vecs[k].rido);
      check($sformatf("v%0d rt_o", k), rt_o, vecs[k].rto);
      check($sformatf("v%0d mask_o", k), mask_o, vecs[k].masko);
      check($sformatf("v%0d sel_o", k), sel_o, vecs[k].sel);
      check($sformatf("v%0d busy", k), busy, vecs[k].infl != 0);
      check($sformatf("v%0d inflight", k), inflight, vecs[k].infl);
      step();
    end
    drive_idle();
    step();

    // Reset mid-operation: MUL at cycle 0, rst low cycles 4..5, released cycle 6.
    issue_v = 1; issue_cls = 0; issue_tid = 3; issue_rt = 1; issue_mask = 4'h1;
    step();
    drive_idle();
    step(); step(); step();
    check("r1 busy before", busy, 1);
    check("r1 inflight before", inflight, 1);
    rst = 0;
    #1;
    check_zero_out("r1 asserted");
    check("r1 issue_rdy asserted", issue_rdy, 0);
    step();
    check("r1 issue_rdy held", issue_rdy, 0);
    step();
    rst = 1;
    #1;
    check("r1 issue_rdy released", issue_rdy, 1);
    for (int c = 6; c <= 10; c++) begin
      check($sformatf("r1 c%0d done", c), done, 0);
      check($sformatf("r1 c%0d inflight", c), inflight, 0);
      step();
    end

    // Reset while an op is completing: outputs drop at once.
    issue_v = 1; issue_cls = 3; issue_tid = 9; issue_rt = 33; issue_mask = 4'hA;
    step();
    drive_idle();
    repeat (4) step();
    check("r2 done", done, 1);
    check("r2 rido", rido, 9);
    check("r2 sel_o", sel_o, 3);
    #2;
    rst = 0;
    #1;
    check_zero_out("r2 asserted");
    step();
    rst = 1;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("r2 post%0d done", c), done, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
